// File: rtl/fp_exec_ctrl.sv
// fp_exec_ctrl: multi-cycle issue/writeback controller for the single-precision
// FP execution unit. Latches operands and control from decode and drives the
// combinational FP ALU. Stalls the pipeline for a per-operation latency so the
// ALU has several cycles to settle. Then it captures either the ALU result for
// register writeback, or the ALU zero flag into the FP condition flag (c.eq.s).
module fp_exec_ctrl #(
    parameter int frac_width = 23,
    parameter int exp_width  = 8,
    parameter int LAT_ADD    = 2,
    parameter int LAT_MUL    = 3,
    parameter int LAT_DIV    = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [2:0]                          op_i,
    input  logic                                cmp_i,
    input  logic [frac_width+exp_width:0]       data1_i,
    input  logic [frac_width+exp_width:0]       data2_i,
    input  logic [4:0]                          rd_i,
    output logic [frac_width+exp_width:0]       alu_a_o,
    output logic [frac_width+exp_width:0]       alu_b_o,
    output logic [2:0]                          alu_ctrl_o,
    input  logic [frac_width+exp_width:0]       alu_data_i,
    input  logic                                alu_zero_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                wb_en_o,
    output logic [4:0]                          wb_addr_o,
    output logic [frac_width+exp_width:0]       wb_data_o,
    output logic                                fcc_o
);

    localparam int W       = frac_width + exp_width + 1;
    localparam int LAT_MAX = (LAT_DIV > LAT_MUL) ? ((LAT_DIV > LAT_ADD) ? LAT_DIV : LAT_ADD)
                                                 : ((LAT_MUL > LAT_ADD) ? LAT_MUL : LAT_ADD);
    localparam int CNT_W   = $clog2(LAT_MAX) + 1;

    localparam logic [2:0] OP_MUL = 3'b000;
    localparam logic [2:0] OP_DIV = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     alu_a_q, alu_a_d;
    logic [W-1:0]     alu_b_q, alu_b_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [4:0]       rd_q, rd_d;
    logic             cmp_q, cmp_d;
    logic [W-1:0]     wb_data_q, wb_data_d;
    logic [4:0]       wb_addr_q, wb_addr_d;
    logic             fcc_q, fcc_d;
    logic [2:0]       eff_op;

    // Counter preload: the EXEC state lasts exactly L cycles, counting L-1 down to 0.
    function automatic logic [CNT_W-1:0] cnt_preload(input logic [2:0] op);
        logic [CNT_W-1:0] v;
        case (op)
            OP_MUL:  v = CNT_W'(LAT_MUL - 1);
            OP_DIV:  v = CNT_W'(LAT_DIV - 1);
            default: v = CNT_W'(LAT_ADD - 1);
        endcase
        return v;
    endfunction

    // A compare always runs as a subtraction so the ALU zero flag reflects equality.
    assign eff_op = cmp_i ? OP_SUB : op_i;

    // Next-state logic: issue in IDLE/DONE, count down in EXEC, capture at the last EXEC cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        ctrl_d    = ctrl_q;
        rd_d      = rd_q;
        cmp_d     = cmp_q;
        wb_data_d = wb_data_q;
        wb_addr_d = wb_addr_q;
        fcc_d     = fcc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    alu_a_d = data1_i;
                    alu_b_d = data2_i;
                    ctrl_d  = eff_op;
                    rd_d    = rd_i;
                    cmp_d   = cmp_i;
                    cnt_d   = cnt_preload(eff_op);
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                // start_i is deliberately not looked at here: decode holds while busy.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    wb_data_d = alu_data_i;
                    wb_addr_d = rd_q;
                    if (cmp_q) begin
                        fcc_d = alu_zero_i;
                    end
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything including the condition flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            ctrl_q    <= 3'b000;
            rd_q      <= '0;
            cmp_q     <= 1'b0;
            wb_data_q <= '0;
            wb_addr_q <= '0;
            fcc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            ctrl_q    <= ctrl_d;
            rd_q      <= rd_d;
            cmp_q     <= cmp_d;
            wb_data_q <= wb_data_d;
            wb_addr_q <= wb_addr_d;
            fcc_q     <= fcc_d;
        end
    end

    // Status outputs decoded from the state register only, so no path from start_i.
    always_comb begin
        busy_o  = (state_q == S_EXEC);
        done_o  = (state_q == S_DONE);
        wb_en_o = (state_q == S_DONE) && !cmp_q;
    end

    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign alu_ctrl_o = ctrl_q;
    assign wb_addr_o  = wb_addr_q;
    assign wb_data_o  = wb_data_q;
    assign fcc_o      = fcc_q;

endmodule

// File: tb/tb_fp_exec_ctrl.sv
// Bench for fp_exec_ctrl: a behavioural FP ALU drives alu_data_i/alu_zero_i,
// while a cycle-level expectation model (latency table plus a flag variable)
// predicts busy/done/writeback/fcc for directed and randomized operations.
module tb_fp_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, cmp;
    logic [2:0]  op;
    logic [31:0] d1, d2;
    logic [4:0]  rd;
    logic [31:0] alu_a, alu_b, alu_data, wb_data;
    logic [2:0]  alu_ctrl;
    logic        alu_zero, busy, done, wb_en, fcc;
    logic [4:0]  wb_addr;

    int   checks   = 0;
    int   failures = 0;
    logic fcc_exp  = 1'b0;

    always #5 clk = ~clk;

    fp_exec_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .op_i       (op),
        .cmp_i      (cmp),
        .data1_i    (d1),
        .data2_i    (d2),
        .rd_i       (rd),
        .alu_a_o    (alu_a),
        .alu_b_o    (alu_b),
        .alu_ctrl_o (alu_ctrl),
        .alu_data_i (alu_data),
        .alu_zero_i (alu_zero),
        .busy_o     (busy),
        .done_o     (done),
        .wb_en_o    (wb_en),
        .wb_addr_o  (wb_addr),
        .wb_data_o  (wb_data),
        .fcc_o      (fcc)
    );

    // Single-precision (normals and zero) to real
    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) d = {b[31], 63'd0};
        else d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Real to single precision (truncating, normal range)
    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e == 11'd0) return {d[63], 31'd0};
        if (e == 11'h7FF) return {d[63], 8'hFF, 23'd0};
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    // Behavioural FP ALU: add, sub, mult, div; anything else yields the difference
    function automatic logic [31:0] fpu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        real ra, rb, r;
        ra = sp2r(a);
        rb = sp2r(b);
        case (c)
            3'b010:  r = ra + rb;
            3'b000:  r = ra * rb;
            3'b001:  r = (rb == 0.0) ? 1.0e300 * 1.0e300 : ra / rb;
            default: r = ra - rb;
        endcase
        return r2sp(r);
    endfunction

    always_comb begin
        alu_data = fpu(alu_ctrl, alu_a, alu_b);
        alu_zero = (alu_data[30:0] == 31'd0);
    end

    function automatic int lat_of(input logic [2:0] eop);
        if (eop == 3'b000) return 3;
        if (eop == 3'b001) return 8;
        return 2;
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_fcc", 32'(fcc), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
    endtask

    // Issue one op at the current negedge and follow it to its DONE cycle.
    // Returns positioned at the DONE-cycle negedge with start already dropped.
    task automatic run_op(input logic [2:0] o, input logic c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input bit hold, input bit use_exp, input logic [31:0] exp_res);
        logic [2:0]  eo;
        logic [31:0] res;
        int          L;
        eo  = c ? 3'b110 : o;
        L   = lat_of(eo);
        res = use_exp ? exp_res : fpu(eo, a, b);
        start = 1'b1; op = o; cmp = c; d1 = a; d2 = b; rd = r;
        for (int i = 1; i <= L; i++) begin
            @(negedge clk);
            if (!hold) begin
                start = 1'b0;
            end else begin
                d1 = $urandom; d2 = $urandom; rd = 5'($urandom);
                op = 3'($urandom); cmp = 1'($urandom);
            end
            chk("exec_busy", 32'(busy), 32'd1);
            chk("exec_done", 32'(done), 32'd0);
            chk("exec_wb_en", 32'(wb_en), 32'd0);
            if (i == 1) begin
                chk("alu_ctrl", 32'(alu_ctrl), 32'(eo));
                chk("alu_a", alu_a, a);
                chk("alu_b", alu_b, b);
            end
        end
        if (c) fcc_exp = (res[30:0] == 31'd0);
        @(negedge clk);
        start = 1'b0;
        chk("done", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("wb_en", 32'(wb_en), c ? 32'd0 : 32'd1);
        chk("wb_addr", 32'(wb_addr), 32'(r));
        chk("wb_data", wb_data, res);
        chk("fcc", 32'(fcc), 32'(fcc_exp));
    endtask

    task automatic idle_cycle();
        logic [31:0] held;
        held = wb_data;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_wb_en", 32'(wb_en), 32'd0);
        chk("idle_wb_hold", wb_data, held);
        chk("idle_fcc", 32'(fcc), 32'(fcc_exp));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cmp = 1'b0; op = 3'b010; d1 = '0; d2 = '0; rd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_state();
        idle_cycle();

        // add and div with known results
        run_op(3'b010, 1'b0, 32'h3FC00000, 32'h40100000, 5'd3, 1'b0, 1'b1, 32'h40700000);
        idle_cycle();
        run_op(3'b001, 1'b0, 32'h3F800000, 32'h40800000, 5'd7, 1'b0, 1'b1, 32'h3E800000);
        idle_cycle();

        // compares, with an add in between that must not touch fcc
        run_op(3'b010, 1'b1, 32'h40000000, 32'h40000000, 5'd1, 1'b0, 1'b0, 32'd0);
        chk("cmp_eq_fcc", 32'(fcc), 32'd1);
        idle_cycle();
        run_op(3'b010, 1'b0, 32'h3F800000, 32'h3F800000, 5'd2, 1'b0, 1'b1, 32'h40000000);
        chk("add_keeps_fcc", 32'(fcc), 32'd1);
        idle_cycle();
        run_op(3'b000, 1'b1, 32'h40000000, 32'h40400000, 5'd4, 1'b0, 1'b0, 32'd0);
        chk("cmp_ne_fcc", 32'(fcc), 32'd0);
        idle_cycle();
        run_op(3'b001, 1'b1, 32'h00000000, 32'h80000000, 5'd5, 1'b0, 1'b0, 32'd0);
        chk("cmp_pm0_fcc", 32'(fcc), 32'd1);
        idle_cycle();

        // start held through EXEC is ignored, then a mult issued in the DONE cycle
        run_op(3'b010, 1'b0, 32'h40400000, 32'h3F800000, 5'd9, 1'b1, 1'b1, 32'h40800000);
        run_op(3'b000, 1'b0, 32'h40400000, 32'hC0000000, 5'd10, 1'b0, 1'b1, 32'hC0C00000);
        idle_cycle();

        // reset in EXEC cycle 4 of a div (fcc is 1 going in)
        start = 1'b1; op = 3'b001; cmp = 1'b0; d1 = 32'h40800000; d2 = 32'h40000000; rd = 5'd12;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("div_busy_pre_rst", 32'(busy), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fcc_exp = 1'b0;
        chk_reset_state();
        for (int i = 0; i < 6; i++) idle_cycle();
        run_op(3'b010, 1'b0, 32'h3FC00000, 32'h40100000, 5'd13, 1'b0, 1'b1, 32'h40700000);
        idle_cycle();

        // reset and start together: reset wins
        rst = 1'b1; start = 1'b1; op = 3'b001; d1 = 32'h3F800000; d2 = 32'h3F800000; rd = 5'd14;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk_reset_state();
        idle_cycle();

        // undefined opcode runs as difference with add latency
        run_op(3'b111, 1'b0, 32'h40400000, 32'h3F800000, 5'd15, 1'b0, 1'b1, 32'h40000000);
        idle_cycle();

        // randomized sequence
        for (int n = 0; n < 30; n++) begin
            logic [31:0] ra, rb;
            logic        rc;
            ra = rand_fp();
            rc = ($urandom_range(0, 2) == 0);
            rb = (rc && $urandom_range(0, 1) == 1) ? ra : rand_fp();
            if ($urandom_range(0, 7) == 0) begin
                ra = {1'($urandom), 31'd0};
                rb = rc ? {1'($urandom), 31'd0} : rb;
            end
            run_op(3'($urandom_range(0, 7)), rc, ra, rb, 5'($urandom), bit'($urandom_range(0, 3) == 0), 1'b0, 32'd0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
